// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : 8-bit UART transmitter. It sends a start bit, eight data bits
//                LSB first and a stop bit. Bit timing comes from a
//                TICK_DIV-cycle tick divider and TICKS_PER_BIT ticks per bit.
//                When UART_TX_PARITY_EN is defined, an even-parity bit is
//                inserted between the last data bit and the stop bit.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    CLOCK_50 in   1  system clock, rising edge
//    reset    in   1  asynchronous, active-high reset
//    DataIn   in   8  character to send; captured only when a send is accepted
//    send     in   1  level-sensitive transmit request (ignored while busy)
//    TxD      out  1  serial line, idle high, registered
//    busy     out  1  high while a frame is in flight
//    charTX   out  1  one-cycle pulse on the last cycle of the stop bit
//  Optional feature macro: UART_TX_PARITY_EN (even parity bit, 11-bit frame)
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_tx #(
    parameter int TICK_DIV      = 326,
    parameter int TICKS_PER_BIT = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] DataIn,
    input  logic       send,
    output logic       TxD,
    output logic       busy,
    output logic       charTX
);

    localparam int c_DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [c_DIV_W-1:0]  c_DIV_MAX  = c_DIV_W'(TICK_DIV - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_MAX = c_TICK_W'(TICKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [c_DIV_W-1:0]   div_q, div_d;
    logic [c_TICK_W-1:0]  tick_q, tick_d;
    logic [2:0]           idx_q, idx_d;
    logic [7:0]           shreg_q, shreg_d;
    logic                 txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    // Last cycle of the current bit period: every state transition except
    // the IDLE->START acceptance happens here, so bit lengths never drift.
    logic w_bit_end;
    assign w_bit_end = (div_q == c_DIV_MAX) && (tick_q == c_TICK_MAX);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            div_q    <= '0;
            tick_q   <= '0;
            idx_q    <= '0;
            shreg_q  <= 8'h00;
            txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            tick_q   <= tick_d;
            idx_q    <= idx_d;
            shreg_q  <= shreg_d;
            txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Bit timing: divider and tick counter run only while a frame is in
    // flight; holding them at zero in IDLE makes acceptance clear them.
    // ------------------------------------------------------------------
    always_comb begin
        div_d  = '0;
        tick_d = '0;
        if (state_q != ST_IDLE) begin
            if (div_q == c_DIV_MAX) begin
                div_d  = '0;
                tick_d = (tick_q == c_TICK_MAX) ? '0 : tick_q + 1'b1;
            end else begin
                div_d  = div_q + 1'b1;
                tick_d = tick_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and next line value. TxD is computed one cycle ahead so
    // the registered line changes on the same edge as the state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shreg_d  = shreg_q;
        txd_d    = txd_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                txd_d = 1'b1;
                if (send) begin
                    state_d  = ST_START;
                    shreg_d  = DataIn;
                    idx_d    = 3'd0;
                    txd_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^DataIn;
`endif
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                    txd_d   = shreg_q[0];
                    shreg_d = {1'b0, shreg_q[7:1]};
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        txd_d   = parity_q;
`else
                        state_d = ST_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        txd_d   = shreg_q[0];
                        shreg_d = {1'b0, shreg_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    state_d = ST_STOP;
                    txd_d   = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    state_d = ST_IDLE;
                    txd_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    assign TxD    = txd_q;
    assign busy   = (state_q != ST_IDLE);
    assign charTX = (state_q == ST_STOP) && w_bit_end;

endmodule

`default_nettype wire
